// File: rtl/riscv_v_pkg.sv
// Shared vector-pipeline definitions: register file geometry and the writeback tag
// carried through the fixed-latency tag delay stage.
package riscv_v_pkg;

  localparam int unsigned VREG_ADDR_W = 5;
  localparam int unsigned NUM_VREGS   = 32;

  typedef struct packed {
    logic                   valid;
    logic [VREG_ADDR_W-1:0] addr;
  } vreg_tag_t;

endpackage

// File: rtl/riscv_v_sb_cnt.sv
// One scoreboard cell: outstanding-write counter for a single vector register.
// Increment and decrement together cancel; decrement at zero holds and flags underflow.
module riscv_v_sb_cnt #(
  parameter int unsigned CNT_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output logic nonzero,
  output logic full,
  output logic underflow
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             underflow_d;

  always_comb begin
    cnt_d       = cnt_q;
    underflow_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec) begin
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && !inc) begin
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      else             underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign nonzero   = (cnt_q != '0);
  assign full      = (cnt_q == '1);
  assign underflow = underflow_d;

endmodule

// File: rtl/riscv_v_vreg_scoreboard.sv
// Vector register scoreboard: marks destinations pending at issue, stalls RAW readers,
// and retires pending marks from the delayed writeback tag.
module riscv_v_vreg_scoreboard
  import riscv_v_pkg::*;
#(
  parameter int unsigned NUM_VREGS = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned CNT_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [ADDR_W-1:0]    issue_vs1,
  input  logic [ADDR_W-1:0]    issue_vs2,
  input  logic [ADDR_W-1:0]    issue_vs3,
  input  logic                 issue_vs1_re,
  input  logic                 issue_vs2_re,
  input  logic                 issue_vs3_re,
  input  logic [ADDR_W-1:0]    issue_vd,
  input  logic                 issue_vd_we,
  input  logic [ADDR_W:0]      wb_tag,
  output logic [NUM_VREGS-1:0] pending,
  output logic                 err_underflow
);

  logic [NUM_VREGS-1:0] cnt_nz, cnt_full, cnt_inc, cnt_dec, cnt_uf;
  logic                 wb_valid;
  logic [ADDR_W-1:0]    wb_addr;
  logic                 raw, full, fire;
  logic                 err_underflow_q, err_underflow_d;

  assign {wb_valid, wb_addr} = wb_tag;

  // Hazards look only at registered counters; a same-cycle writeback does not release a reader.
  always_comb begin
    raw = (issue_vs1_re && cnt_nz[issue_vs1]) ||
          (issue_vs2_re && cnt_nz[issue_vs2]) ||
          (issue_vs3_re && cnt_nz[issue_vs3]);
    full        = issue_vd_we && cnt_full[issue_vd];
    issue_ready = !flush && !raw && !full;
    fire        = issue_valid && issue_ready;
  end

  for (genvar r = 0; r < NUM_VREGS; r++) begin : g_cnt
    assign cnt_inc[r] = fire && issue_vd_we && (issue_vd == ADDR_W'(r));
    assign cnt_dec[r] = wb_valid && (wb_addr == ADDR_W'(r));

    riscv_v_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .clr       (flush),
      .inc       (cnt_inc[r]),
      .dec       (cnt_dec[r]),
      .nonzero   (cnt_nz[r]),
      .full      (cnt_full[r]),
      .underflow (cnt_uf[r])
    );
  end

  always_comb begin
    err_underflow_d = err_underflow_q || (|cnt_uf);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_underflow_q <= 1'b0;
    else     err_underflow_q <= err_underflow_d;
  end

  assign pending       = cnt_nz;
  assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_riscv_v_vreg_scoreboard.sv
// Directed bench for the vector register scoreboard; stimulus queues expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_riscv_v_vreg_scoreboard;
  import riscv_v_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_vs1, issue_vs2, issue_vs3, issue_vd;
  logic        issue_vs1_re, issue_vs2_re, issue_vs3_re, issue_vd_we;
  vreg_tag_t   wb_tag;
  logic [31:0] pending;
  logic        err_underflow;

  riscv_v_vreg_scoreboard #(.NUM_VREGS(32), .ADDR_W(5), .CNT_W(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_vs1     (issue_vs1),
    .issue_vs2     (issue_vs2),
    .issue_vs3     (issue_vs3),
    .issue_vs1_re  (issue_vs1_re),
    .issue_vs2_re  (issue_vs2_re),
    .issue_vs3_re  (issue_vs3_re),
    .issue_vd      (issue_vd),
    .issue_vd_we   (issue_vd_we),
    .wb_tag        (wb_tag),
    .pending       (pending),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] pmask;
    logic [31:0] pval;
    logic        rdy;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic err_exp = 1'b0;
  bit   stim_done = 1'b0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      if ((pending & e.pmask) !== (e.pval & e.pmask)) begin
        miscompares++;
        $display("FAIL %s pending: got %h want %h (mask %h)", e.name, pending & e.pmask,
                 e.pval & e.pmask, e.pmask);
      end
      if (issue_ready !== e.rdy) begin
        miscompares++;
        $display("FAIL %s issue_ready: got %b want %b", e.name, issue_ready, e.rdy);
      end
      if (err_underflow !== e.err) begin
        miscompares++;
        $display("FAIL %s err_underflow: got %b want %b", e.name, err_underflow, e.err);
      end
    end
  end

  task automatic chk_reg(input string n, input int r, input logic pv, input logic rdy);
    exp_t e;
    e.name = n; e.pmask = 32'd1 << r; e.pval = {31'd0, pv} << r; e.rdy = rdy; e.err = err_exp;
    exp_q.push_back(e);
  endtask

  task automatic chk_all(input string n, input logic [31:0] pv, input logic rdy);
    exp_t e;
    e.name = n; e.pmask = '1; e.pval = pv; e.rdy = rdy; e.err = err_exp;
    exp_q.push_back(e);
  endtask

  task automatic idle_in();
    flush = 1'b0; issue_valid = 1'b0;
    issue_vs1 = '0; issue_vs2 = '0; issue_vs3 = '0; issue_vd = '0;
    issue_vs1_re = 1'b0; issue_vs2_re = 1'b0; issue_vs3_re = 1'b0; issue_vd_we = 1'b0;
    wb_tag = '{valid: 1'b0, addr: 5'd0};
  endtask

  task automatic issue_wr(input logic [4:0] vd);
    idle_in();
    issue_valid = 1'b1; issue_vd = vd; issue_vd_we = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    tick();
    chk_all("reset_hold", 32'd0, 1'b1);
    tick();
    #2 rst = 1'b0;
    tick();
    chk_all("idle", 32'd0, 1'b1);

    // RAW stall on v3 until its writeback tag has been seen
    tick(); issue_wr(5'd3); chk_all("raw_issue", 32'd0, 1'b1);
    tick(); idle_in(); issue_valid = 1'b1; issue_vs1 = 5'd3; issue_vs1_re = 1'b1;
    chk_reg("raw_stall0", 3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk_reg("raw_stall", 3, 1'b1, 1'b0);
    end
    tick(); wb_tag = '{valid: 1'b1, addr: 5'd3};
    chk_reg("raw_wb_nobypass", 3, 1'b1, 1'b0);
    tick(); wb_tag = '{valid: 1'b0, addr: 5'd0};
    chk_all("raw_release", 32'd0, 1'b1);

    // WAW counting on v7 up to saturation
    tick(); issue_wr(5'd7); chk_reg("waw_i1", 7, 1'b0, 1'b1);
    tick(); chk_reg("waw_i2", 7, 1'b1, 1'b1);
    tick(); chk_reg("waw_i3", 7, 1'b1, 1'b1);
    tick(); chk_reg("waw_full", 7, 1'b1, 1'b0);
    tick(); idle_in(); wb_tag = '{valid: 1'b1, addr: 5'd7};
    chk_reg("waw_wb1", 7, 1'b1, 1'b1);
    tick(); issue_vd = 5'd7; issue_vd_we = 1'b1;
    chk_reg("waw_wb2_notfull", 7, 1'b1, 1'b1);
    tick(); issue_vd_we = 1'b0; chk_reg("waw_wb3", 7, 1'b1, 1'b1);
    tick(); idle_in(); chk_all("waw_drained", 32'd0, 1'b1);

    // fire and writeback to v5 in the same cycle leave the count at 1
    tick(); issue_wr(5'd5); chk_all("sim_first", 32'd0, 1'b1);
    tick(); wb_tag = '{valid: 1'b1, addr: 5'd5};
    chk_reg("sim_both", 5, 1'b1, 1'b1);
    tick(); idle_in(); chk_all("sim_cnt1", 32'h0000_0020, 1'b1);
    tick(); wb_tag = '{valid: 1'b1, addr: 5'd5};
    chk_reg("sim_last_wb", 5, 1'b1, 1'b1);
    tick(); idle_in(); chk_all("sim_drained", 32'd0, 1'b1);

    // flush beats a simultaneous fire and writeback
    tick(); issue_wr(5'd9); chk_all("fl_setup", 32'd0, 1'b1);
    tick(); issue_wr(5'd12); flush = 1'b1; wb_tag = '{valid: 1'b1, addr: 5'd9};
    chk_all("fl_during", 32'h0000_0200, 1'b0);
    tick(); idle_in(); chk_all("fl_after", 32'd0, 1'b1);

    // underflow on v10 is sticky through flush
    tick(); wb_tag = '{valid: 1'b1, addr: 5'd10};
    chk_all("uf_cycle", 32'd0, 1'b1);
    tick(); idle_in(); err_exp = 1'b1; chk_all("uf_set", 32'd0, 1'b1);
    tick(); flush = 1'b1; chk_all("uf_flush", 32'd0, 1'b0);
    tick(); idle_in(); chk_all("uf_sticky", 32'd0, 1'b1);

    // disabled reads never stall; enabled ones on each port do
    tick(); issue_wr(5'd10); chk_all("re_setup", 32'd0, 1'b1);
    tick(); idle_in(); issue_valid = 1'b1;
    issue_vs1 = 5'd10; issue_vs2 = 5'd10; issue_vs3 = 5'd10;
    chk_reg("re_all_off", 10, 1'b1, 1'b1);
    tick(); issue_vs2_re = 1'b1; chk_reg("re_vs2_on", 10, 1'b1, 1'b0);
    tick(); issue_vs2_re = 1'b0; issue_vs3_re = 1'b1;
    chk_reg("re_vs3_on", 10, 1'b1, 1'b0);

    // asynchronous reset mid-operation
    tick(); idle_in(); rst = 1'b1; err_exp = 1'b0;
    chk_all("async_rst", 32'd0, 1'b1);
    tick(); #2 rst = 1'b0;
    tick(); chk_all("post_rst", 32'd0, 1'b1);
    tick(); issue_wr(5'd1); chk_all("post_rst_issue", 32'd0, 1'b1);
    tick(); idle_in(); chk_all("post_rst_pend", 32'h0000_0002, 1'b1);
    tick(); tick();
    stim_done = 1'b1;
  end

  initial begin
    for (int c = 0; c < 2000 && !stim_done; c++) @(posedge clk);
    if (!stim_done) begin
      miscompares++;
      $display("FAIL timeout: stimulus did not complete, got running want done");
    end
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d unchecked entries want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
